// File: rtl/noise_test_pkg.sv
// Shared types and constants for the noise-test sequencer.
// Holds the FSM state encoding, PRBS7 seed/taps and the display saturation limit.
package noise_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [6:0]  PRBS7_SEED = 7'h7F;
  localparam logic [6:0]  PRBS7_TAPS = 7'b110_0000;  // x^7 + x^6 + 1
  localparam int unsigned ERR_LIMIT  = 9999;

endpackage

// File: rtl/noise_prbs7.sv
// PRBS7 (x^7+x^6+1) pattern source; output is the MSB of the shift register.
// Instantiated by noise_test_sequencer only when NOISE_SEQ_PRBS_EN is defined.
module noise_prbs7
  import noise_test_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic advance_i,
  output logic bit_o
);

  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = PRBS7_SEED;
    end else if (advance_i) begin
      lfsr_d = {lfsr_q[5:0], ^(lfsr_q & PRBS7_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[6];

endmodule

// File: rtl/noise_test_sequencer.sv
// Sequences one noise-test run: drives a pattern on pin_1, samples pin_2, counts mismatches.
// Define NOISE_SEQ_PRBS_EN for a PRBS7 pattern; otherwise a 1,0,1,0... toggle is driven.
module noise_test_sequencer
  import noise_test_pkg::*;
#(
  parameter int BIT_CYCLES    = 50,
  parameter int SETTLE_CYCLES = 10,
  parameter int NUM_BITS      = 1000,
  parameter int CNT_W         = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pin_2,
  output logic             pin_1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  localparam int CYC_W = $clog2(BIT_CYCLES);
  localparam int BIT_W = $clog2(NUM_BITS + 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] PREF_CYC = CYC_W'(BIT_CYCLES - 2);
  localparam logic [CYC_W-1:0] SMP_CYC  = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(ERR_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic               start_q;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               pin_1_q, pin_1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pat_load, pat_adv, pat_bit;

`ifdef NOISE_SEQ_PRBS_EN
  noise_prbs7 u_prbs (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pat_load),
    .advance_i (pat_adv),
    .bit_o     (pat_bit)
  );
`else
  logic tog_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q <= 1'b0;
    end else if (pat_load) begin
      tog_q <= 1'b1;
    end else if (pat_adv) begin
      tog_q <= ~tog_q;
    end
  end

  assign pat_bit = tog_q;
`endif

  // The generator is advanced one cycle before the bit boundary so that the
  // registered pin_1 can pick up the next bit exactly on the boundary.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    err_d    = err_q;
    result_d = result_q;
    pat_load = 1'b0;
    pat_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) state_d = S_ARM;
      end
      S_ARM: begin
        cyc_d    = '0;
        bit_d    = '0;
        err_d    = '0;
        pat_load = 1'b1;
        state_d  = S_DRIVE;
      end
      S_DRIVE: begin
        if (cyc_q == SMP_CYC && pin_2 != pin_1_q) err_d = sat_inc(err_q);
        if (cyc_q == PREF_CYC) pat_adv = 1'b1;
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (bit_q == LAST_BIT) state_d = S_DONE;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) result_d = err_d;
    busy_d = (state_d == S_ARM) || (state_d == S_DRIVE);
    done_d = (state_d == S_DONE);

    // Bit 0 is 1 in every pattern mode, so it is driven while the generator loads.
    if (state_q == S_ARM)                                pin_1_d = 1'b1;
    else if (state_d == S_DRIVE && cyc_q == LAST_CYC)    pin_1_d = pat_bit;
    else if (state_d == S_DRIVE)                         pin_1_d = pin_1_q;
    else                                                 pin_1_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      cyc_q    <= '0;
      bit_q    <= '0;
      err_q    <= '0;
      result_q <= '0;
      pin_1_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      result_q <= result_d;
      pin_1_q  <= pin_1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pin_1  = pin_1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_noise_test_sequencer.sv
// Scoreboard bench for noise_test_sequencer: randomized runs against a sequence-level model.
module tb_noise_test_sequencer;

  localparam int BC  = 3;
  localparam int SC  = 2;
  localparam int NB  = 127;
  localparam int BC2 = 2;
  localparam int SC2 = 1;
  localparam int NB2 = 10002;

  logic        clk = 1'b0;
  logic        reset, start, pin_2;
  logic        pin_1, busy, done;
  logic [13:0] result;
  logic        sat_start, sat_pin_2;
  logic        sat_pin_1, sat_busy, sat_done;
  logic [13:0] sat_result;

  always #5 clk = ~clk;

  noise_test_sequencer #(.BIT_CYCLES(BC), .SETTLE_CYCLES(SC), .NUM_BITS(NB), .CNT_W(14)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pin_2(pin_2),
    .pin_1(pin_1), .busy(busy), .done(done), .result(result)
  );

  noise_test_sequencer #(.BIT_CYCLES(BC2), .SETTLE_CYCLES(SC2), .NUM_BITS(NB2), .CNT_W(14)) u_sat (
    .clk(clk), .reset(reset), .start(sat_start), .pin_2(sat_pin_2),
    .pin_1(sat_pin_1), .busy(sat_busy), .done(sat_done), .result(sat_result)
  );

  assign sat_pin_2 = ~sat_pin_1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int blen = 0;
  int sat_dones = 0;
  bit model[NB];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected result whenever the DUT pulses done.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with result %0d, expected no done", result);
      end else begin
        check("result", int'(result), exp_q.pop_front());
      end
    end
    if (reset) begin
      blen = 0;
    end else if (busy) begin
      blen++;
    end else if (blen != 0) begin
      check("busy_len", blen, 1 + NB * BC);
      blen = 0;
    end
    if (sat_done) begin
      sat_dones++;
      check("sat_result", int'(sat_result), 9999);
    end
  end

  task automatic run_one(input int mode, input bit hold, input int abort_cyc);
    bit p2[NB];
    int exp_err = 0;
    int cyc = 0;
    for (int k = 0; k < NB; k++) begin
      case (mode)
        0:       p2[k] = model[k];
        1:       p2[k] = 1'b0;
        2:       p2[k] = ~model[k];
        default: p2[k] = model[k] ^ ($urandom_range(0, 3) == 0);
      endcase
      if (p2[k] != model[k]) exp_err++;
    end
    @(negedge clk);
    start = 1'b1;
    if (abort_cyc == 0) exp_q.push_back(exp_err);
    @(negedge clk);
    check("busy_after_edge", int'(busy), 1);
    check("pin1_in_arm", int'(pin_1), 0);
    if (!hold) start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < BC; c++) begin
        @(negedge clk);
        cyc++;
        if (abort_cyc != 0 && cyc == abort_cyc) begin
          reset = 1'b1;
          @(negedge clk);
          check("abort_busy", int'(busy), 0);
          check("abort_pin1", int'(pin_1), 0);
          check("abort_result", int'(result), 0);
          check("abort_done", int'(done), 0);
          reset = 1'b0;
          start = 1'b0;
          return;
        end
        if (c == 0) begin
          pin_2 = p2[k];
          check("pin1_bit", int'(pin_1), int'(model[k]));
        end
        if (!hold && $urandom_range(0, 15) == 0) start = ~start;
      end
    end
    @(negedge clk);
    check("done_busy", int'(busy), 0);
    check("done_pulse", int'(done), 1);
    repeat (5) begin
      @(negedge clk);
      check("no_relaunch", int'(busy), 0);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
`ifdef NOISE_SEQ_PRBS_EN
    for (int n = 0; n < NB; n++) model[n] = (n < 7) ? 1'b1 : (model[n-7] ^ model[n-6]);
`else
    for (int n = 0; n < NB; n++) model[n] = (n % 2 == 0);
`endif
    reset = 1'b1;
    start = 1'b0;
    pin_2 = 1'b0;
    sat_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_pin1", int'(pin_1), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_sat_busy", int'(sat_busy), 0);
    reset = 1'b0;
    @(negedge clk);

    run_one(0, 1'b0, 0);
    run_one(1, 1'b0, 0);
    run_one(2, 1'b1, 0);
    run_one(3, 1'b0, 0);
    run_one(3, 1'b0, 100);
    run_one(0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      run_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    w = 0;
    while (sat_dones == 0 && w < 30000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("sat_done_count", sat_dones, 1);
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
